// File: rtl/mem_copy_engine_if.sv
// Bus bundle between the copy engine, the control unit and the single-port data memory.
// The engine uses the master view; the surrounding environment uses the slave view.
interface mem_copy_engine_if #(
    parameter int ADDRESS_BITS = 11,
    parameter int DATA_BITS    = 16
);
    logic                    i_start;
    logic [ADDRESS_BITS-1:0] i_src_addr;
    logic [ADDRESS_BITS-1:0] i_dst_addr;
    logic [ADDRESS_BITS:0]   i_length;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_read;
    logic                    o_write;
    logic [ADDRESS_BITS-1:0] o_address;
    logic [DATA_BITS-1:0]    o_data;
    logic [DATA_BITS-1:0]    i_data;

    modport master (
        input  i_start, i_src_addr, i_dst_addr, i_length, i_data,
        output o_busy, o_done, o_read, o_write, o_address, o_data
    );

    modport slave (
        output i_start, i_src_addr, i_dst_addr, i_length, i_data,
        input  o_busy, o_done, o_read, o_write, o_address, o_data
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy engine: moves i_length words from i_src_addr to i_dst_addr in a single-port
// memory, one read then one write per word in ascending order, addresses wrapping modulo depth.
module mem_copy_engine #(
    parameter int ADDRESS_BITS = 11,
    parameter int DATA_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_copy_engine_if.master     bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDRESS_BITS-1:0] r_src;
    logic [ADDRESS_BITS-1:0] r_dst;
    logic [ADDRESS_BITS:0]   r_len;
    logic [ADDRESS_BITS:0]   r_idx;
    logic [ADDRESS_BITS-1:0] r_address;
    logic [DATA_BITS-1:0]    r_data;
    logic [ADDRESS_BITS:0]   w_idx_inc;
    logic                    w_last;

    // idx is one bit wider than an address so a full-memory length terminates cleanly
    assign w_idx_inc = r_idx + 1'b1;
    assign w_last    = (w_idx_inc == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_next = (bus.i_length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_WRITE;
            S_WRITE:   w_next = w_last ? S_DONE : S_READ;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // The address register is loaded on the edge entering READ/WRITE so it is stable while
    // the strobe is high and simply holds in CAPTURE, DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_address <= '0;
            r_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_src <= bus.i_src_addr;
                        r_dst <= bus.i_dst_addr;
                        r_len <= bus.i_length;
                        r_idx <= '0;
                        if (bus.i_length != '0) begin
                            r_address <= bus.i_src_addr;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_data    <= bus.i_data;
                    r_address <= r_dst + r_idx[ADDRESS_BITS-1:0];
                end
                S_WRITE: begin
                    r_idx <= w_idx_inc;
                    if (!w_last) begin
                        r_address <= r_src + w_idx_inc[ADDRESS_BITS-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_read    = (r_state == S_READ);
    assign bus.o_write   = (r_state == S_WRITE);
    assign bus.o_busy    = (r_state == S_READ) || (r_state == S_CAPTURE) || (r_state == S_WRITE);
    assign bus.o_done    = (r_state == S_DONE);
    assign bus.o_address = r_address;
    assign bus.o_data    = r_data;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a behavioural memory serves the port, and a reference memory
// is updated by a plain word-by-word ascending copy to predict the final contents.
module tb_mem_copy_engine;
    localparam int AB    = 11;
    localparam int DB    = 16;
    localparam int DEPTH = 1 << AB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_copy_engine_if #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) bus ();

    mem_copy_engine #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DB-1:0] tb_mem  [0:DEPTH-1];
    logic [DB-1:0] ref_mem [0:DEPTH-1];
    logic          poke_en = 1'b0;
    logic [AB-1:0] poke_addr = '0;
    logic [DB-1:0] poke_val = '0;

    int n_checks = 0;
    int n_pass   = 0;

    // free-running monitor totals; tasks take snapshots and compare deltas
    int mon_busy = 0, mon_done = 0, mon_both = 0, mon_reads = 0, mon_writes = 0;
    logic [AB-1:0] rd_log [0:8191];

    initial begin
        for (int a = 0; a < DEPTH; a++) tb_mem[a] = DB'($urandom);
        bus.i_data = '0;
        forever begin
            @(posedge clk);
            if (bus.o_read)  bus.i_data <= tb_mem[bus.o_address];
            if (bus.o_write) tb_mem[bus.o_address] <= bus.o_data;
            if (poke_en)     tb_mem[poke_addr] <= poke_val;
        end
    end

    always @(negedge clk) begin
        if (bus.o_busy) mon_busy++;
        if (bus.o_done) mon_done++;
        if (bus.o_read && bus.o_write) mon_both++;
        if (bus.o_read) begin
            rd_log[mon_reads % 8192] = bus.o_address;
            mon_reads++;
        end
        if (bus.o_write) mon_writes++;
    end

    function automatic int mem_diffs();
        int d = 0;
        for (int a = 0; a < DEPTH; a++) if (tb_mem[a] !== ref_mem[a]) d++;
        return d;
    endfunction

    task automatic ref_copy(input int src, input int dst, input int len);
        for (int i = 0; i < len; i++) ref_mem[(dst + i) % DEPTH] = ref_mem[(src + i) % DEPTH];
    endtask

    task automatic poke(input int a, input logic [DB-1:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = AB'(a); poke_val = v;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[a] = v;
    endtask

    // Issues one start, waits (bounded) for o_done, updates the reference, idles one cycle.
    task automatic do_copy(input int src, input int dst, input int len, input int limit,
                           output int done_at);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_src_addr = AB'(src); bus.i_dst_addr = AB'(dst);
        bus.i_length = (AB + 1)'(len);
        @(negedge clk);
        bus.i_start = 1'b0;
        done_at = -1;
        for (int c = 1; c <= limit; c++) begin
            if (bus.o_done) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        ref_copy(src, dst, len);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.o_busy); else n_pass++;
        n_checks++; if (bus.o_done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.o_done); else n_pass++;
        n_checks++; if (bus.o_read !== 1'b0) $display("FAIL reset_read got %b want 0", bus.o_read); else n_pass++;
        n_checks++; if (bus.o_write !== 1'b0) $display("FAIL reset_write got %b want 0", bus.o_write); else n_pass++;
        n_checks++; if (bus.o_address !== '0) $display("FAIL reset_address got %0d want 0", bus.o_address); else n_pass++;
        n_checks++; if (bus.o_data !== '0) $display("FAIL reset_data got %h want 0", bus.o_data); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DB-1:0] v [4];
        int b0, d0, x0, done_at;
        for (int i = 0; i < 4; i++) begin
            v[i] = DB'($urandom);
            poke(100 + i, v[i]);
        end
        b0 = mon_busy; d0 = mon_done; x0 = mon_both;
        do_copy(100, 200, 4, 100, done_at);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tb_mem[200 + i] !== v[i]) $display("FAIL basic_word%0d got %h want %h", i, tb_mem[200 + i], v[i]);
            else n_pass++;
        end
        n_checks++; if (mon_busy - b0 !== 12) $display("FAIL basic_busy_cycles got %0d want 12", mon_busy - b0); else n_pass++;
        n_checks++; if (mon_done - d0 !== 1) $display("FAIL basic_done_pulses got %0d want 1", mon_done - d0); else n_pass++;
        n_checks++; if (mon_both - x0 !== 0) $display("FAIL basic_read_and_write got %0d want 0", mon_both - x0); else n_pass++;
        n_checks++; if (done_at !== 13) $display("FAIL basic_done_latency got %0d want 13", done_at); else n_pass++;
    endtask

    task automatic test_zero_length();
        int r0, w0, done_at;
        r0 = mon_reads; w0 = mon_writes;
        do_copy(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), 0, 20, done_at);
        n_checks++; if (done_at !== 1) $display("FAIL zero_done_latency got %0d want 1", done_at); else n_pass++;
        n_checks++; if (mon_reads - r0 !== 0 || mon_writes - w0 !== 0)
            $display("FAIL zero_strobes got reads=%0d writes=%0d want 0/0", mon_reads - r0, mon_writes - w0);
        else n_pass++;
        n_checks++; if (mem_diffs() !== 0) $display("FAIL zero_memory got %0d differing words want 0", mem_diffs()); else n_pass++;
    endtask

    task automatic test_wrap();
        int r0, done_at;
        int exp_rd [4] = '{2046, 2047, 0, 1};
        int exp_wr [4] = '{1, 2, 1, 2};
        poke(2046, 16'd1); poke(2047, 16'd2); poke(0, 16'd3); poke(1, 16'd4);
        r0 = mon_reads;
        do_copy(2046, 0, 4, 100, done_at);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (int'(rd_log[(r0 + i) % 8192]) !== exp_rd[i])
                $display("FAIL wrap_read_addr%0d got %0d want %0d", i, rd_log[(r0 + i) % 8192], exp_rd[i]);
            else n_pass++;
            n_checks++;
            if (int'(tb_mem[i]) !== exp_wr[i]) $display("FAIL wrap_word%0d got %0d want %0d", i, tb_mem[i], exp_wr[i]);
            else n_pass++;
        end
        n_checks++; if (mem_diffs() !== 0) $display("FAIL wrap_memory got %0d differing words want 0", mem_diffs()); else n_pass++;
    endtask

    task automatic test_overlap();
        int done_at;
        poke(10, 16'h5A5A);
        do_copy(10, 11, 3, 100, done_at);
        for (int i = 11; i <= 13; i++) begin
            n_checks++;
            if (tb_mem[i] !== 16'h5A5A) $display("FAIL overlap_word%0d got %h want 5a5a", i, tb_mem[i]);
            else n_pass++;
        end
        n_checks++; if (mem_diffs() !== 0) $display("FAIL overlap_memory got %0d differing words want 0", mem_diffs()); else n_pass++;
    endtask

    task automatic test_ignore_start();
        int b0, d0, done_at;
        b0 = mon_busy; d0 = mon_done;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_src_addr = 11'd500; bus.i_dst_addr = 11'd900; bus.i_length = 12'd6;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        bus.i_start = 1'b1; bus.i_src_addr = 11'd1500; bus.i_dst_addr = 11'd1600; bus.i_length = 12'd3;
        @(negedge clk);
        bus.i_start = 1'b0;
        done_at = -1;
        for (int c = 0; c < 100; c++) begin
            if (bus.o_done) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (done_at < 0) $display("FAIL ignore_done_timeout got none want pulse"); else n_pass++;
        // start presented during DONE must not launch a second copy
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        ref_copy(500, 900, 6);
        n_checks++; if (mon_busy - b0 !== 18) $display("FAIL ignore_busy_cycles got %0d want 18", mon_busy - b0); else n_pass++;
        n_checks++; if (mon_done - d0 !== 1) $display("FAIL ignore_done_pulses got %0d want 1", mon_done - d0); else n_pass++;
        n_checks++; if (mem_diffs() !== 0) $display("FAIL ignore_memory got %0d differing words want 0", mem_diffs()); else n_pass++;
    endtask

    task automatic test_reset_mid_copy();
        int d0, w_seen, done_at;
        bit found;
        d0 = mon_done;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_src_addr = 11'd300; bus.i_dst_addr = 11'd700; bus.i_length = 12'd8;
        @(negedge clk);
        bus.i_start = 1'b0;
        w_seen = 0; found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.o_write) begin
                w_seen++;
                if (w_seen == 3) begin
                    found = 1'b1;
                    break;
                end
            end
            @(negedge clk);
        end
        n_checks++; if (!found) $display("FAIL rstmid_write_timeout got %0d writes want 3", w_seen); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", bus.o_busy); else n_pass++;
        n_checks++; if (bus.o_read !== 1'b0 || bus.o_write !== 1'b0)
            $display("FAIL rstmid_strobes got r=%b w=%b want 0/0", bus.o_read, bus.o_write);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        ref_copy(300, 700, 2);
        n_checks++; if (mon_done - d0 !== 0) $display("FAIL rstmid_done_pulses got %0d want 0", mon_done - d0); else n_pass++;
        n_checks++; if (mem_diffs() !== 0) $display("FAIL rstmid_memory got %0d differing words want 0", mem_diffs()); else n_pass++;
        do_copy(40, 60, 5, 100, done_at);
        n_checks++; if (done_at !== 16) $display("FAIL rstmid_restart_latency got %0d want 16", done_at); else n_pass++;
        n_checks++; if (mem_diffs() !== 0) $display("FAIL rstmid_restart_memory got %0d differing words want 0", mem_diffs()); else n_pass++;
    endtask

    task automatic test_random_copies();
        int src, dst, len, b0, d0, x0, r0, w0, done_at;
        for (int t = 0; t < 9; t++) begin
            src = int'($urandom_range(0, DEPTH - 1));
            dst = (t % 3 == 0) ? (src + int'($urandom_range(1, 5))) % DEPTH : int'($urandom_range(0, DEPTH - 1));
            len = (t == 8) ? DEPTH : int'($urandom_range(1, 64));
            b0 = mon_busy; d0 = mon_done; x0 = mon_both; r0 = mon_reads; w0 = mon_writes;
            do_copy(src, dst, len, 3 * len + 20, done_at);
            n_checks++; if (done_at !== 3 * len + 1)
                $display("FAIL rand%0d_done_latency got %0d want %0d", t, done_at, 3 * len + 1);
            else n_pass++;
            n_checks++; if (mon_busy - b0 !== 3 * len || mon_done - d0 !== 1)
                $display("FAIL rand%0d_busy_done got busy=%0d done=%0d want %0d/1", t, mon_busy - b0, mon_done - d0, 3 * len);
            else n_pass++;
            n_checks++; if (mon_reads - r0 !== len || mon_writes - w0 !== len || mon_both - x0 !== 0)
                $display("FAIL rand%0d_strobes got r=%0d w=%0d both=%0d want %0d/%0d/0", t,
                         mon_reads - r0, mon_writes - w0, mon_both - x0, len, len);
            else n_pass++;
            n_checks++; if (mem_diffs() !== 0) $display("FAIL rand%0d_memory got %0d differing words want 0", t, mem_diffs());
            else n_pass++;
        end
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_src_addr = '0; bus.i_dst_addr = '0; bus.i_length = '0;
        #1;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = tb_mem[a];
        test_reset();
        test_basic();
        test_zero_length();
        test_wrap();
        test_overlap();
        test_ignore_start();
        test_reset_mid_copy();
        test_random_copies();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
